// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/valid handshake, absorbs stalls with a one-entry skid buffer and feeds IF/ID.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              stall_if,
    input  logic              jump,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [5:0]        opcode
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_BUFFERED = 2'd2,
        S_DISCARD  = 2'd3
    } state_t;

    // J-type target: upper PC nibble of the delay slot, 26-bit index, word aligned.
    function automatic logic [DATA_W-1:0] jump_target(input logic [DATA_W-1:0] pc4,
                                                      input logic [DATA_W-1:0] instr);
        jump_target = {pc4[31:28], instr[25:0], 2'b00};
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] r_redir_pc;
    logic [DATA_W-1:0] w_redir_pc_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] w_instr_nxt;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] w_pc4_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [DATA_W-1:0] r_skid_instr;
    logic [DATA_W-1:0] w_skid_instr_nxt;
    logic [DATA_W-1:0] r_skid_pc4;
    logic [DATA_W-1:0] w_skid_pc4_nxt;
    logic              r_skid_valid;
    logic              w_skid_valid_nxt;

    logic              w_complete;
    logic              w_redirect;
    logic [DATA_W-1:0] w_target;
    logic [DATA_W-1:0] w_pc_plus4;

    // A branch outranks the stall; a jump only counts once the stall has cleared.
    assign w_complete = r_req & imem_valid;
    assign w_redirect = branch_taken | (jump & ~stall_if);
    assign w_target   = branch_taken ? branch_target : jump_target(r_pc4, r_instr);
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_req_nxt  = (w_state_nxt == S_WAIT) || (w_state_nxt == S_DISCARD);

    // Next-state, PC, skid buffer and IF/ID update.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_redir_pc_nxt   = r_redir_pc;
        w_instr_nxt      = r_instr;
        w_pc4_nxt        = r_pc4;
        w_valid_nxt      = r_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc4_nxt   = r_skid_pc4;
        w_skid_valid_nxt = r_skid_valid;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_WAIT;
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            S_WAIT: begin
                if (w_redirect) begin
                    if (w_complete) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_redir_pc_nxt = w_target;
                        w_state_nxt    = S_DISCARD;
                    end
                end else if (w_complete) begin
                    if (stall_if) begin
                        w_skid_instr_nxt = imem_rdata;
                        w_skid_pc4_nxt   = w_pc_plus4;
                        w_skid_valid_nxt = 1'b1;
                        w_state_nxt      = S_BUFFERED;
                    end else begin
                        w_instr_nxt = imem_rdata;
                        w_pc4_nxt   = w_pc_plus4;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_plus4;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_BUFFERED: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_WAIT;
                end else if (!stall_if) begin
                    w_instr_nxt      = r_skid_instr;
                    w_pc4_nxt        = r_skid_pc4;
                    w_valid_nxt      = r_skid_valid;
                    w_skid_valid_nxt = 1'b0;
                    w_pc_nxt         = w_pc_plus4;
                    w_state_nxt      = S_WAIT;
                end else begin
                    w_state_nxt = S_BUFFERED;
                end
            end
            S_DISCARD: begin
                // The stale response must still be consumed before refetching.
                if (w_complete) begin
                    w_pc_nxt    = w_redirect ? w_target : r_redir_pc;
                    w_state_nxt = S_WAIT;
                end else if (w_redirect) begin
                    w_redir_pc_nxt = w_target;
                end else begin
                    w_state_nxt = S_DISCARD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_redirect) begin
            w_instr_nxt      = '0;
            w_valid_nxt      = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = w_valid_nxt;
        end
    end

    // State, PC, skid and IF/ID registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= PC_RESET;
            r_redir_pc   <= '0;
            r_req        <= 1'b0;
            r_instr      <= '0;
            r_pc4        <= '0;
            r_valid      <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc4   <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_req        <= w_req_nxt;
            r_instr      <= w_instr_nxt;
            r_pc4        <= w_pc4_nxt;
            r_valid      <= w_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc4   <= w_skid_pc4_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end

    assign imem_req       = r_req;
    assign imem_addr      = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus4 = r_pc4;
    assign if_id_valid    = r_valid;
    assign opcode         = r_instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a behavioural fetch model and a variable-latency memory responder.
module tb_fetch_stage;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        stall_if = 1'b0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 0;
    int mem_cnt = 0;

    // behavioural model of the fetch stage
    logic        m_boot, m_fetching, m_dropping, m_held, m_valid;
    logic [31:0] m_pc, m_redir, m_instr, m_pc4, m_skid_instr;

    fetch_stage #(.PC_RESET(PC_RESET), .DATA_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .stall_if(stall_if), .jump(jump),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .opcode(opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h2008_0005;
            32'h0000_0004: mem_word = 32'h8C09_0004;
            32'h0000_0008: mem_word = 32'hAC09_0008;
            32'h1000_0004: mem_word = 32'h0800_0010;
            default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic model_reset();
        m_boot = 1'b1; m_fetching = 1'b0; m_dropping = 1'b0; m_held = 1'b0;
        m_valid = 1'b0; m_pc = PC_RESET; m_redir = 32'd0; m_instr = 32'd0;
        m_pc4 = 32'd0; m_skid_instr = 32'd0;
    endtask

    // One clock edge of the reference: what the fetch stage should hold afterwards.
    task automatic model_edge(input logic st, input logic jp, input logic bt,
                              input logic [31:0] tgt, input logic vld, input logic [31:0] rd);
        logic done, redir;
        logic [31:0] dest;
        done  = m_fetching && vld;
        redir = bt || (jp && !st);
        dest  = bt ? tgt : {m_pc4[31:28], m_instr[25:0], 2'b00};
        if (m_boot) begin
            m_boot = 1'b0;
            m_fetching = 1'b1;
            if (redir) m_pc = dest;
        end else if (redir) begin
            if (m_fetching && !done) begin
                m_dropping = 1'b1;
                m_redir = dest;
            end else begin
                m_pc = dest; m_dropping = 1'b0; m_fetching = 1'b1;
            end
        end else if (m_dropping) begin
            if (done) begin
                m_dropping = 1'b0;
                m_pc = m_redir;
            end
        end else if (m_held) begin
            if (!st) begin
                m_instr = m_skid_instr; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_held = 1'b0; m_fetching = 1'b1;
            end
        end else if (done) begin
            if (st) begin
                m_skid_instr = rd; m_held = 1'b1; m_fetching = 1'b0;
            end else begin
                m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end
        if (redir) begin
            m_valid = 1'b0; m_instr = 32'd0; m_held = 1'b0;
        end
    endtask

    // One cycle: memory answers at the falling edge, model advances, outputs settle after the rising edge.
    task automatic step();
        logic req_s, done_s;
        @(negedge clk);
        if (imem_req && mem_cnt >= mem_lat) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else if (imem_req) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end else begin
            imem_valid = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
        end
        req_s  = imem_req;
        done_s = imem_req && imem_valid;
        model_edge(stall_if, jump, branch_taken, branch_target, imem_valid, imem_rdata);
        @(posedge clk);
        #1;
        if (!req_s || done_s) mem_cnt = 0;
        else mem_cnt = mem_cnt + 1;
    endtask

    task automatic apply_reset();
        #2;
        arst_n = 1'b0;
        stall_if = 1'b0; jump = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        mem_cnt = 0; mem_lat = 0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b0, PC_RESET}) begin
            n_bad++;
            $display("FAIL reset_fetch: got req=%b addr=%h expected req=0 addr=%h", imem_req, imem_addr, PC_RESET);
        end
        n_cmp++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus4, opcode} !== {1'b0, 32'd0, 32'd0, 6'd0}) begin
            n_bad++;
            $display("FAIL reset_ifid: got v=%b instr=%h pc4=%h op=%h expected all zero",
                     if_id_valid, if_id_instr, if_id_pc_plus4, opcode);
        end
        release_reset();
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_req: got %b expected 0", imem_req);
        end
    endtask

    task automatic test_seq_zero_latency();
        logic [5:0]  exp_op [3];
        logic [31:0] exp_pc4 [3];
        exp_op  = '{6'h08, 6'h23, 6'h2B};
        exp_pc4 = '{32'd4, 32'd8, 32'd12};
        apply_reset();
        release_reset();
        step();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL seq_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({if_id_valid, opcode, if_id_pc_plus4} !== {1'b1, exp_op[i], exp_pc4[i]}) begin
                n_bad++;
                $display("FAIL seq_load%0d: got v=%b op=%h pc4=%h expected v=1 op=%h pc4=%h",
                         i, if_id_valid, opcode, if_id_pc_plus4, exp_op[i], exp_pc4[i]);
            end
        end
    endtask

    task automatic test_stall_skid();
        apply_reset();
        release_reset();
        mem_lat = 3;
        step();
        stall_if = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            step();
            n_cmp++;
            if ({if_id_valid, if_id_instr} !== {1'b0, 32'd0}) begin
                n_bad++;
                $display("FAIL stall_hold_c%0d: got v=%b instr=%h expected v=0 instr=0", c, if_id_valid, if_id_instr);
            end
        end
        stall_if = 1'b0;
        step();
        n_cmp++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus4, imem_req, imem_addr} !==
            {1'b1, 32'h2008_0005, 32'd4, 1'b1, 32'd4}) begin
            n_bad++;
            $display("FAIL stall_release: got v=%b instr=%h pc4=%h req=%b addr=%h expected 1 20080005 4 1 4",
                     if_id_valid, if_id_instr, if_id_pc_plus4, imem_req, imem_addr);
        end
        for (int k = 0; k < 10 && if_id_pc_plus4 != 32'd8; k++) step();
        n_cmp++;
        if ({if_id_instr, if_id_pc_plus4} !== {32'h8C09_0004, 32'd8}) begin
            n_bad++;
            $display("FAIL stall_next: got instr=%h pc4=%h expected 8c090004 8", if_id_instr, if_id_pc_plus4);
        end
    endtask

    task automatic test_branch_discard();
        apply_reset();
        release_reset();
        step();
        for (int k = 0; k < 10 && imem_addr != 32'h10; k++) step();
        mem_lat = 3;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        branch_target = 32'd0;
        for (int k = 0; k < 8 && m_dropping; k++) begin
            n_cmp++;
            if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h10, 1'b0}) begin
                n_bad++;
                $display("FAIL discard_hold: got req=%b addr=%h v=%b expected req=1 addr=10 v=0",
                         imem_req, imem_addr, if_id_valid);
            end
            step();
        end
        n_cmp++;
        if ({imem_req, imem_addr, if_id_valid, if_id_instr} !== {1'b1, 32'h40, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL discard_refetch: got req=%b addr=%h v=%b instr=%h expected 1 40 0 0",
                     imem_req, imem_addr, if_id_valid, if_id_instr);
        end
    endtask

    task automatic test_jump();
        apply_reset();
        release_reset();
        step();
        branch_taken = 1'b1;
        branch_target = 32'h1000_0004;
        step();
        branch_taken = 1'b0;
        step();
        n_cmp++;
        if ({if_id_instr, if_id_pc_plus4} !== {32'h0800_0010, 32'h1000_0008}) begin
            n_bad++;
            $display("FAIL jump_setup: got instr=%h pc4=%h expected 08000010 10000008", if_id_instr, if_id_pc_plus4);
        end
        jump = 1'b1;
        step();
        jump = 1'b0;
        n_cmp++;
        if ({imem_addr, if_id_instr, if_id_valid} !== {32'h1000_0040, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL jump_redirect: got addr=%h instr=%h v=%b expected 10000040 0 0",
                     imem_addr, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_branch_beats_jump();
        apply_reset();
        release_reset();
        step();
        step();
        jump = 1'b1; branch_taken = 1'b1; branch_target = 32'h80; stall_if = 1'b1;
        step();
        jump = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; stall_if = 1'b0;
        n_cmp++;
        if ({imem_addr, if_id_valid} !== {32'h80, 1'b0}) begin
            n_bad++;
            $display("FAIL prio_addr: got addr=%h v=%b expected 80 0", imem_addr, if_id_valid);
        end
        step();
        n_cmp++;
        if ({if_id_instr, if_id_pc_plus4} !== {mem_word(32'h80), 32'h84}) begin
            n_bad++;
            $display("FAIL prio_load: got instr=%h pc4=%h expected %h 84", if_id_instr, if_id_pc_plus4, mem_word(32'h80));
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        release_reset();
        step(); step(); step();
        mem_lat = 3;
        step();
        n_cmp++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'd8, 1'b1}) begin
            n_bad++;
            $display("FAIL rstmid_pre: got req=%b addr=%h v=%b expected 1 8 1", imem_req, imem_addr, if_id_valid);
        end
        apply_reset();
        n_cmp++;
        if ({imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4} !==
            {1'b0, PC_RESET, 1'b0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL rstmid_async: got req=%b addr=%h v=%b instr=%h pc4=%h expected all reset",
                     imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4);
        end
        release_reset();
        step();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, PC_RESET}) begin
            n_bad++;
            $display("FAIL rstmid_refetch: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, PC_RESET);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        release_reset();
        step();
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        branch_target = 32'd0;
        step();
        n_cmp++;
        if ({imem_addr, if_id_pc_plus4, if_id_instr} !== {32'd0, 32'd0, mem_word(32'hFFFF_FFFC)}) begin
            n_bad++;
            $display("FAIL wrap: got addr=%h pc4=%h instr=%h expected 0 0 %h",
                     imem_addr, if_id_pc_plus4, if_id_instr, mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        apply_reset();
        release_reset();
        for (int i = 0; i < 1500; i++) begin
            stall_if     = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 15) == 0);
            branch_taken = ($urandom_range(0, 15) == 0);
            t = $urandom;
            branch_target = {t[31:2], 2'b00};
            if ($urandom_range(0, 9) == 0) mem_lat = $urandom_range(0, 3);
            step();
            n_cmp++;
            if ({imem_req, imem_addr} !== {m_fetching, m_pc}) begin
                n_bad++;
                $display("FAIL rnd_fetch@%0d: got req=%b addr=%h expected req=%b addr=%h",
                         i, imem_req, imem_addr, m_fetching, m_pc);
            end
            n_cmp++;
            if ({if_id_valid, if_id_instr, if_id_pc_plus4, opcode} !== {m_valid, m_instr, m_pc4, m_instr[31:26]}) begin
                n_bad++;
                $display("FAIL rnd_ifid@%0d: got v=%b instr=%h pc4=%h op=%h expected v=%b instr=%h pc4=%h",
                         i, if_id_valid, if_id_instr, if_id_pc_plus4, opcode, m_valid, m_instr, m_pc4);
            end
        end
        stall_if = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq_zero_latency();
        test_stall_skid();
        test_branch_discard();
        test_jump();
        test_branch_beats_jump();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
